// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM read arbiter slice.
package sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_REFRESH = 2'd3
  } state_e;

  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int DATA_W = 16;
  localparam int PEND_W = 3;

  localparam logic [DATA_W-1:0] RD_TIMEOUT_DATA = 16'hDEAD;
  localparam logic [PEND_W-1:0] PEND_MAX        = '1;

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval counter with a saturating count of owed refreshes.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 780
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic ack_i,
  output logic pending_o
);

  localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              wrap;

  always_comb begin
    wrap   = (cnt_q == CNT_W'(REF_INTERVAL - 1));
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    pend_d = pend_q;
    // A wrap and an ack in the same cycle cancel out.
    if (wrap && !ack_i && pend_q != PEND_MAX)
      pend_d = pend_q + 1'b1;
    else if (ack_i && !wrap && pend_q != '0)
      pend_d = pend_q - 1'b1;
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = (pend_q != '0);

endmodule

// File: rtl/sdram_rd_arbiter.sv
// Two-requester round-robin read arbiter in front of the SDRAM controller,
// with refresh scheduling and a read timeout.
module sdram_rd_arbiter
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 780,
  parameter int RD_TIMEOUT   = 64
) (
  input  logic              clk_100MHz,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              rd_err,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rd_req,
  input  logic [DATA_W-1:0] ctrl_rd_data,
  input  logic              ctrl_rd_ready,
  output logic              ref_req,
  input  logic              ref_ack
);

  localparam int TO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q, fin_data;
  logic              rv0_q, rv0_d, rv1_q, rv1_d, err_q, err_d;
  logic              fin, ref_pend, ref_done;

  sdram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .ack_i      (ref_done),
    .pending_o  (ref_pend)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    to_d     = to_q;
    fin      = 1'b0;
    fin_data = ctrl_rd_data;
    err_d    = 1'b0;
    ref_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ref_pend) begin
          state_d = ST_REFRESH;
        end else if (req0_valid || req1_valid) begin
          // On a tie, hand the grant to whoever did not get the last one.
          gnt_d   = req1_valid & (~req0_valid | ~gnt_q);
          addr_d  = gnt_d ? req1_addr : req0_addr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        to_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ctrl_rd_ready) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end else if (to_q == TO_W'(RD_TIMEOUT - 1)) begin
          fin      = 1'b1;
          fin_data = RD_TIMEOUT_DATA;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_REFRESH: begin
        if (ref_ack) begin
          ref_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rv0_d = fin & ~gnt_q;
    rv1_d = fin & gnt_q;
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b1;
      addr_q   <= '0;
      to_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      to_q    <= to_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      err_q   <= err_d;
      if (rv0_d) rdata0_q <= fin_data;
      if (rv1_d) rdata1_q <= fin_data;
    end
  end

  // Strobes decode straight from state, so they can never overlap.
  assign req0_ready  = (state_q == ST_ISSUE) && !gnt_q;
  assign req1_ready  = (state_q == ST_ISSUE) && gnt_q;
  assign ctrl_rd_req = (state_q == ST_ISSUE);
  assign ref_req     = (state_q == ST_REFRESH);
  assign ctrl_addr   = addr_q;
  assign req0_rvalid = rv0_q;
  assign req1_rvalid = rv1_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign rd_err      = err_q;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Scoreboard bench for sdram_rd_arbiter: reads, round-robin, refresh, timeout, reset.
module tb_sdram_rd_arbiter;

  localparam int REF_I = 20;
  localparam int RD_TO = 64;

  logic        clk, rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_addr, req1_addr, ctrl_addr;
  logic        req0_rvalid, req1_rvalid, rd_err, ctrl_rd_req, ctrl_rd_ready;
  logic [15:0] req0_rdata, req1_rdata, ctrl_rd_data;
  logic        ref_req, ref_ack;

  sdram_rd_arbiter #(.REF_INTERVAL(REF_I), .RD_TIMEOUT(RD_TO)) u_dut (
    .clk_100MHz(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .rd_err(rd_err), .ctrl_addr(ctrl_addr), .ctrl_rd_req(ctrl_rd_req),
    .ctrl_rd_data(ctrl_rd_data), .ctrl_rd_ready(ctrl_rd_ready),
    .ref_req(ref_req), .ref_ack(ref_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [15:0] q0[$], q1[$];
  int n_rdy0, n_rdy1, n_rv0, n_rv1, n_err, n_rdreq, n_ack;
  bit ack_en, ref_seen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready) n_rdy0++;
      if (req1_ready) n_rdy1++;
      if (ctrl_rd_req) n_rdreq++;
      if (rd_err) n_err++;
      if (ref_req) ref_seen = 1'b1;
      if (ctrl_rd_req || ref_req) chk("excl", {31'd0, ctrl_rd_req & ref_req}, 0);
      if (req0_rvalid) begin
        n_rv0++;
        if (q0.size() == 0) chk("rv0_unexp", 1, 0);
        else chk("rdata0", {16'd0, req0_rdata}, {16'd0, q0.pop_front()});
      end
      if (req1_rvalid) begin
        n_rv1++;
        if (q1.size() == 0) chk("rv1_unexp", 1, 0);
        else chk("rdata1", {16'd0, req1_rdata}, {16'd0, q1.pop_front()});
      end
    end
  end

  // Refresh acknowledger.
  initial begin
    ref_ack = 1'b0;
    forever begin
      @(negedge clk);
      ref_ack = ack_en && ref_req && rst_n;
      if (ref_ack) n_ack++;
    end
  end

  task automatic clr_cnt();
    n_rdy0 = 0; n_rdy1 = 0; n_rv0 = 0; n_rv1 = 0; n_err = 0; n_rdreq = 0; n_ack = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    ctrl_rd_ready = 1'b0; ctrl_rd_data = '0;
    ack_en = 1'b1;
    q0.delete(); q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr_cnt();
  endtask

  task automatic wait_rdy(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rdy_timeout", 0, 1);
  endtask

  // Call at the negedge of the ISSUE cycle; returns at the negedge rvalid should show.
  task automatic ctrl_reply(input int lat, input logic [15:0] d);
    repeat (lat) @(negedge clk);
    ctrl_rd_data = d;
    ctrl_rd_ready = 1'b1;
    @(negedge clk);
    ctrl_rd_ready = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u_dut.u_ref.cnt_q == v) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("cnt_timeout", 0, 1);
  endtask

  initial begin
    bit ok, who;
    int k, snap;
    rst_n = 1'b1;
    req0_addr = '0; req1_addr = '0;
    clr_cnt();

    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_addr", ctrl_addr, 0);
    chk("rst_pulses", {req0_ready, req1_ready, req0_rvalid, req1_rvalid, rd_err, ctrl_rd_req, ref_req}, 0);
    chk("rst_rdata", {req0_rdata, req1_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_cnt();

    // Single read
    req0_addr = 24'h40_1203;
    req0_valid = 1'b1;
    q0.push_back(16'hA5A5);
    wait_rdy(0, ok);
    chk("single_rdreq", ctrl_rd_req, 1);
    chk("single_addr", ctrl_addr, 24'h40_1203);
    req0_valid = 1'b0;
    ctrl_reply(8, 16'hA5A5);
    chk("single_lat", req0_rvalid, 1);
    chk("single_addr_hold", ctrl_addr, 24'h40_1203);
    repeat (5) @(negedge clk);
    chk("single_n_rdy", n_rdy0, 1);
    chk("single_n_rdreq", n_rdreq, 1);
    chk("single_n_rv", n_rv0, 1);

    // Round-robin with both requesters held valid
    do_reset();
    req0_addr = 24'h00_0100; req1_addr = 24'h80_0200;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) q0.push_back(16'h1000 + 16'(i));
      else q1.push_back(16'h1000 + 16'(i));
    end
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("rr_timeout", 0, 1);
      who = req1_ready;
      chk("rr_gnt", {31'd0, who}, i % 2);
      chk("rr_addr", ctrl_addr, who ? 24'h80_0200 : 24'h00_0100);
      if (i >= 2) begin
        if (who) req1_valid = 1'b0;
        else req0_valid = 1'b0;
      end
      ctrl_reply(3 + i, 16'h1000 + 16'(i));
      chk("rr_rv", who ? req1_rvalid : req0_rvalid, 1);
    end
    repeat (10) @(negedge clk);
    chk("rr_n_gnt", n_rdy0 + n_rdy1, 4);

    // Refresh wraps while a read is in WAIT
    do_reset();
    repeat (25) @(negedge clk);
    wait_cnt(2);
    ack_en = 1'b0;
    ref_seen = 1'b0;
    req0_addr = 24'h12_3400;
    req0_valid = 1'b1;
    q0.push_back(16'h5A5A);
    wait_rdy(0, ok);
    req0_valid = 1'b0;
    ctrl_reply(25, 16'h5A5A);
    chk("ref_rv", req0_rvalid, 1);
    chk("ref_pre", {31'd0, ref_seen}, 0);
    chk("ref_pend", u_dut.u_ref.pend_q, 1);
    req1_addr = 24'h01_0001;
    req1_valid = 1'b1;
    q1.push_back(16'hBEEF);
    @(negedge clk);
    chk("ref_rise", ref_req, 1);
    repeat (6) @(negedge clk);
    chk("ref_hold", ref_req, 1);
    chk("ref_no_gnt", n_rdy1, 0);
    ack_en = 1'b1;
    wait_rdy(1, ok);
    req1_valid = 1'b0;
    ctrl_reply(4, 16'hBEEF);
    chk("ref_rv1", req1_rvalid, 1);

    // Pending-count saturation
    do_reset();
    ack_en = 1'b0;
    repeat (10 * REF_I + 5) @(negedge clk);
    chk("sat_pend", u_dut.u_ref.pend_q, 7);
    chk("sat_ref", ref_req, 1);
    wait_cnt(0);
    n_ack = 0;
    ack_en = 1'b1;
    repeat (16) @(negedge clk);
    chk("sat_n_ack", n_ack, 7);
    chk("sat_ref_low", ref_req, 0);
    chk("sat_pend0", u_dut.u_ref.pend_q, 0);

    // Timeout with a late ctrl_rd_ready
    do_reset();
    req1_addr = 24'h12_3456;
    req1_valid = 1'b1;
    q1.push_back(16'hDEAD);
    wait_rdy(1, ok);
    req1_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      k++;
      if (rd_err) break;
    end
    chk("to_cycles", k, RD_TO + 1);
    chk("to_rv1", req1_rvalid, 1);
    ctrl_rd_data = 16'h1234;
    ctrl_rd_ready = 1'b1;
    @(negedge clk);
    ctrl_rd_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("to_late_rv", n_rv1, 1);
    chk("to_n_err", n_err, 1);

    // Reset during WAIT
    do_reset();
    req0_addr = 24'h0A_BCDE;
    req0_valid = 1'b1;
    q0.push_back(16'h7777);
    wait_rdy(0, ok);
    ctrl_reply(2, 16'h7777);
    q0.push_back(16'h1111);
    wait_rdy(0, ok);
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    snap = n_rv0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", ctrl_addr, 0);
    chk("mid_rst_rdata0", req0_rdata, 0);
    chk("mid_rst_pulses", {req0_ready, req1_ready, req0_rvalid, req1_rvalid, rd_err, ctrl_rd_req, ref_req}, 0);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ctrl_rd_data = 16'h1111;
    ctrl_rd_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      ctrl_rd_ready = 1'b0;
      k++;
      if (ref_req) break;
    end
    chk("mid_rst_no_rv", n_rv0, snap);
    // Pending sets after REF_I edges; the FSM needs one more to enter REFRESH.
    chk("mid_rst_ref1", k, REF_I + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_rd_arbiter.md
SDRAM_RD_ARBITER -- requirements
Module: sdram_rd_arbiter

Interface
REQ-001 SHALL have parameter REF_INTERVAL, default 780, meaning clock cycles between refresh requests (7.8 us at 100 MHz).
REQ-002 SHALL have parameter RD_TIMEOUT, default 64, meaning the maximum number of cycles to wait for ctrl_rd_ready before aborting.
REQ-003 SHALL have the following ports (name, direction, width, meaning), clock and reset first:
- clk_100MHz  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 (UART host) read request.
- req0_addr  in  24  requester 0 address {bank[23:22], row[21:9], col[8:0]}.
- req0_ready  out  1  one-cycle pulse: request 0 accepted.
- req0_rvalid  out  1  one-cycle pulse: req0_rdata valid.
- req0_rdata  out  16  read data for requester 0.
- req1_valid / req1_addr / req1_ready / req1_rvalid / req1_rdata: same as requester 0, for requester 1 (test pattern checker).
- rd_err  out  1  one-cycle pulse: the current read timed out.
- ctrl_addr  out  24  address to the SDRAM controller.
- ctrl_rd_req  out  1  one-cycle read strobe to the controller.
- ctrl_rd_data  in  16  controller read data.
- ctrl_rd_ready  in  1  controller read-complete strobe.
- ref_req  out  1  refresh request level to the controller.
- ref_ack  in  1  one-cycle pulse: refresh done.

Function
REQ-004 SHALL implement the FSM states IDLE, ISSUE, WAIT and REFRESH.
REQ-005 SHALL behave in IDLE as follows:
- If refresh is pending, go to REFRESH; refresh has priority over all new grants.
- Otherwise, if any reqN_valid is high, grant one requester, pulse reqN_ready, latch its address into ctrl_addr and go to ISSUE.
REQ-006 SHALL arbitrate round-robin: if both requesters are valid, grant the requester that was not granted last; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-007 SHALL, in ISSUE, assert ctrl_rd_req for exactly one cycle, then go to WAIT.
REQ-008 SHALL hold ctrl_addr stable from the grant cycle until leaving WAIT, because the controller samples the column address after activation.
REQ-009 SHALL behave in WAIT as follows:
- On ctrl_rd_ready, register ctrl_rd_data into the granted reqN_rdata, pulse reqN_rvalid in the next cycle and return to IDLE.
- Latency from ctrl_rd_ready to rvalid is 1 cycle.
REQ-010 SHALL count WAIT cycles and, when the count reaches RD_TIMEOUT, do all of the following:
- pulse rd_err and the granted reqN_rvalid, with reqN_rdata = 16'hDEAD;
- return to IDLE;
- ignore any later ctrl_rd_ready until the next ISSUE.
REQ-011 SHALL run a free-running refresh counter from 0 to REF_INTERVAL-1 that wraps to 0; each wrap increments a 3-bit pending-refresh count, which saturates at 7.
REQ-012 SHALL never preempt a read in flight; refresh waits in IDLE until the read completes or times out.
REQ-013 SHALL, in REFRESH, hold ref_req high until ref_ack. Each ack decrements the pending count and returns the FSM to IDLE; IDLE re-enters REFRESH while the count is nonzero.
REQ-014 SHALL, when a counter wrap and a ref_ack occur in the same cycle, leave the pending count unchanged.
REQ-015 SHALL ignore a ref_ack received outside REFRESH.
REQ-016 SHALL pulse at most one reqN_ready per grant; a requester SHALL keep reqN_valid and reqN_addr stable until its reqN_ready pulse.
REQ-017 SHALL drive ctrl_rd_req and ref_req such that they are never high in the same cycle.

Reset
REQ-018 SHALL, on rst_n low, asynchronously force the following values:
- FSM to IDLE;
- all pulse outputs, ctrl_rd_req and ref_req to 0;
- ctrl_addr, req0_rdata and req1_rdata to 0;
- refresh counter, pending count and timeout counter to 0;
- last-grant pointer to 1.
REQ-019 SHALL, if reset is asserted mid-read or mid-refresh, abandon the operation without returning data; after reset, the first refresh is requested REF_INTERVAL cycles later.

Structure
REQ-020 SHALL place the FSM state encoding, the timeout data value 16'hDEAD and the address field widths in a shared package (sdram_pkg).
REQ-021 SHALL implement the refresh interval counter and pending-count logic as the sub-module sdram_ref_timer.

Verification
REQ-022 SHALL pass a single read: req0 addr 24'h40_1203, controller returns 16'hA5A5 after 8 cycles -> one req0_ready, one ctrl_rd_req with ctrl_addr=24'h40_1203, req0_rvalid with 16'hA5A5 1 cycle after ctrl_rd_ready.
REQ-023 SHALL pass round-robin: both requesters held valid for 4 reads -> grant order 0,1,0,1, with no back-to-back grants to the same requester.
REQ-024 SHALL pass refresh priority: REF_INTERVAL=20, refresh counter wraps while a read is in WAIT -> ref_req rises only after rvalid, and no grant occurs until ref_ack.
REQ-025 SHALL pass saturation: ref_ack withheld for 10 intervals -> pending count stops at 7, and exactly 7 refreshes are issued once acks resume.
REQ-026 SHALL pass timeout: ctrl_rd_ready never arrives -> after 64 WAIT cycles, rd_err and req1_rvalid pulse with 16'hDEAD; a late ctrl_rd_ready is ignored.
REQ-027 SHALL pass reset mid-read: rst_n low during WAIT -> all outputs return to reset values immediately, and no rvalid follows.
